load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 resetn  in  1  reset, asynchronous, active-low.
REQ-003 req_valid  in  1  core presents a load/store request.
REQ-004 req_ready  out  1  unit can accept a request (high only in IDLE).
REQ-005 mem_write  in  1  1=store, 0=load.
REQ-006 ls_b  in  1  byte access.
REQ-007 ls_h  in  1  halfword access; ls_b=ls_h=0 means word access.
REQ-008 load_signext  in  1  1=sign-extend byte/half load data, 0=zero-extend.
REQ-009 addr  in  32  byte address.
REQ-010 wdata  in  32  store data, right-aligned.
REQ-011 done  out  1  one-cycle pulse when a request completes.
REQ-012 load_data  out  32  extended load result, valid while done=1 for a load.
REQ-013 misalign_err  out  1  one-cycle pulse when an accepted request is misaligned.
REQ-014 bus_req  out  1  bus request.
REQ-015 bus_we  out  1  bus write.
REQ-016 bus_addr  out  32  word-aligned address, with addr[1:0] forced to 00.
REQ-017 bus_be  out  4  byte enables.
REQ-018 bus_wdata  out  32  lane-replicated store data.
REQ-019 bus_gnt  in  1  bus accepts the request in the cycle it is high.
REQ-020 bus_rvalid  in  1  read data valid.
REQ-021 bus_rdata  in  32  read data word.

Function
REQ-022 States: IDLE, REQ, WAIT; handshake req_valid&&req_ready accepts a request and registers all request fields.
REQ-023 Misaligned requests (half with addr[0]=1; word with addr[1:0]!=0) stay in IDLE, issue no bus cycle, and pulse misalign_err the next cycle; byte requests are never misaligned.
REQ-024 Aligned accept moves IDLE->REQ; in REQ, bus_req=1 and bus_we/bus_addr/bus_be/bus_wdata hold stable until bus_gnt.
REQ-025 REQ with bus_gnt: a store returns to IDLE and pulses done the next cycle; a load goes to WAIT.
REQ-026 bus_rvalid is honoured only in WAIT (ignored in IDLE/REQ); WAIT with bus_rvalid goes to IDLE and pulses done with registered load_data the next cycle.
REQ-027 Minimum latency is accept->done = 2 cycles for a store and 3 cycles for a load (gnt in the first REQ cycle, rvalid the cycle after).
REQ-028 A new request is accepted in the same cycle done is high (back-to-back operation).
REQ-029 If ls_b=ls_h=1, the access is treated as a byte (ls_b priority).
REQ-030 bus_be encoding: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111.
REQ-031 bus_wdata encoding: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-032 load_data extraction: byte = bus_rdata[8*addr[1:0]+:8]; half = bus_rdata[16*addr[1]+:16]; each extended to 32 bits per load_signext; word passes through unchanged.
REQ-033 Outside REQ, bus_req=0 and bus_be=0000.
REQ-034 done and misalign_err are never high in the same cycle.

Reset
REQ-035 resetn low forces state IDLE and sets done=0, misalign_err=0, load_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0 immediately (asynchronous), so req_ready=1.
REQ-036 Reset in REQ or WAIT abandons the transaction with no done pulse, and the unit ignores a late bus_rvalid after reset.

Structure
REQ-037 Shared package rv32i_lsu_pkg holds the state enum, the size encoding (BYTE/HALF/WORD), and the byte-enable constants.
REQ-038 The sub-module lsu_load_align is purely combinational and performs the REQ-032 extract/extend.

Verification
REQ-039 sb addr=0x1003 wdata=0xAB, gnt after 2 cycles -> bus_be=1000, bus_wdata=0xABABABAB, bus_addr=0x1000, done once.
REQ-040 lh addr=0x2002 signext=1, rdata=0x8001_1234 -> load_data=0xFFFF8001; repeat as lhu -> 0x00008001.
REQ-041 lb addr=0x3001 signext=1, rdata=0x0000_F000 -> load_data=0xFFFFFFF0.
REQ-042 lw addr=0x4002 -> misalign_err pulse, bus_req never asserted, req_ready stays 1.
REQ-043 resetn low while in WAIT, then rvalid arrives -> no done pulse, state IDLE, bus_req=0.
REQ-044 Back-to-back sw 0x10 then lw 0x14 with zero-wait bus -> second request accepted in the done cycle of the first, loads return correct data.

Source files
------------

// File: rtl/rv32i_lsu_pkg.sv
// Shared types and encodings for the RV32I load/store unit.
// Holds the FSM state enum, the access-size encoding and the byte-enable patterns.
package rv32i_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } size_t;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // ls_b wins when both size strobes are set
  function automatic size_t decode_size(input logic b, input logic h);
    if (b)      return BYTE;
    else if (h) return HALF;
    else        return WORD;
  endfunction

  function automatic logic [3:0] byte_enable(input size_t size, input logic [1:0] lo);
    case (size)
      BYTE:    return BE_BYTE << lo;
      HALF:    return lo[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t size, input logic [1:0] lo);
    case (size)
      HALF:    return lo[0];
      WORD:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input size_t size, input logic [31:0] wd);
    case (size)
      BYTE:    return {4{wd[7:0]}};
      HALF:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-bus connection of the load/store unit.
// master = the load/store unit, slave = the memory or interconnect.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load-data lane extraction and sign/zero extension.
// Byte and halfword lanes are selected by the low address bits of the access.
module lsu_load_align
  import rv32i_lsu_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  addr_lo,
  input  logic        signext,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      BYTE:    data = {{24{signext & lane_b[7]}}, lane_b};
      HALF:    data = {{16{signext & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core and a gnt/rvalid memory bus.
// Misaligned requests are rejected in IDLE with a one-cycle misalign_err pulse.
module load_store_unit
  import rv32i_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic        ls_b,
  input  logic        ls_h,
  input  logic        load_signext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign_err,
  load_store_unit_if.master bus
);

  state_t      state, next_state;
  size_t       req_size;
  logic        req_misaligned;
  logic        accept;
  logic        finish;

  size_t       size_q;
  logic        signext_q;
  logic [1:0]  lo_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] aligned_data;

  assign req_size       = decode_size(ls_b, ls_h);
  assign req_misaligned = is_misaligned(req_size, addr[1:0]);

  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // bus_rvalid is only looked at in WAIT, so stray read data after a reset is dropped
  always_comb begin
    next_state  = state;
    req_ready   = 1'b0;
    accept      = 1'b0;
    finish      = 1'b0;
    bus.bus_req = 1'b0;
    bus.bus_be  = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (!req_misaligned) next_state = REQ;
        end
      end
      REQ: begin
        bus.bus_req = 1'b1;
        bus.bus_be  = be_q;
        if (bus.bus_gnt) begin
          next_state = we_q ? IDLE : WAIT;
          finish     = we_q;
        end
      end
      WAIT: begin
        if (bus.bus_rvalid) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  lsu_load_align u_load_align (
    .size    (size_q),
    .addr_lo (lo_q),
    .signext (signext_q),
    .rdata   (bus.bus_rdata),
    .data    (aligned_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done         <= 1'b0;
      misalign_err <= 1'b0;
      load_data    <= '0;
      size_q       <= BYTE;
      signext_q    <= 1'b0;
      lo_q         <= 2'b00;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= 4'b0000;
    end else begin
      done         <= finish;
      misalign_err <= accept && req_misaligned;
      if (accept) begin
        size_q    <= req_size;
        signext_q <= load_signext;
        lo_q      <= addr[1:0];
        we_q      <= mem_write;
        addr_q    <= {addr[31:2], 2'b00};
        wdata_q   <= store_lanes(req_size, wdata);
        be_q      <= byte_enable(req_size, addr[1:0]);
      end
      if (state == WAIT && bus.bus_rvalid) load_data <= aligned_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// The bench plays the core and a memory whose gnt/rvalid timing is chosen per vector.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_write = 1'b0;
  logic        ls_b = 1'b0;
  logic        ls_h = 1'b0;
  logic        load_signext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        done;
  logic [31:0] load_data;
  logic        misalign_err;

  int compared   = 0;
  int mismatched = 0;

  load_store_unit_if bus_if ();

  load_store_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .mem_write    (mem_write),
    .ls_b         (ls_b),
    .ls_h         (ls_h),
    .load_signext (load_signext),
    .addr         (addr),
    .wdata        (wdata),
    .done         (done),
    .load_data    (load_data),
    .misalign_err (misalign_err),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task step;
    @(posedge clk);
    #1;
  endtask

  task present(input logic we, input logic b, input logic h, input logic sx,
               input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    mem_write    = we;
    ls_b         = b;
    ls_h         = h;
    load_signext = sx;
    addr         = a;
    wdata        = wd;
  endtask

  // One request, bus granted after gnt_wait idle REQ cycles, read data the cycle after grant
  task applyStimulus(input string tag, input logic we, input logic b, input logic h,
                     input logic sx, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int gnt_wait, input logic [3:0] exp_be,
                     input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                     input logic [31:0] exp_load);
    present(we, b, h, sx, a, wd);
    step;
    req_valid = 1'b0;
    wdata     = 32'h5A5A_5A5A;
    checkOutput({tag, ".ready_in_req"}, req_ready, 32'd0);
    for (int i = 0; i <= gnt_wait; i++) begin
      checkOutput({tag, ".bus_req"}, bus_if.bus_req, 32'd1);
      checkOutput({tag, ".bus_be"}, bus_if.bus_be, exp_be);
      checkOutput({tag, ".bus_addr"}, bus_if.bus_addr, exp_addr);
      checkOutput({tag, ".bus_we"}, bus_if.bus_we, we);
      if (we) checkOutput({tag, ".bus_wdata"}, bus_if.bus_wdata, exp_wdata);
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = 32'hDEAD_DEAD;
      if (i == gnt_wait) bus_if.bus_gnt = 1'b1;
      step;
      bus_if.bus_gnt    = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      if (i != gnt_wait) checkOutput({tag, ".early_done"}, done, 32'd0);
    end
    if (!we) begin
      checkOutput({tag, ".wait_done"}, done, 32'd0);
      checkOutput({tag, ".wait_bus_req"}, bus_if.bus_req, 32'd0);
      checkOutput({tag, ".wait_bus_be"}, bus_if.bus_be, 32'd0);
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = rd;
      step;
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rdata  = 32'h0;
      checkOutput({tag, ".load_data"}, load_data, exp_load);
    end
    checkOutput({tag, ".done"}, done, 32'd1);
    checkOutput({tag, ".no_misalign"}, misalign_err, 32'd0);
    checkOutput({tag, ".idle_bus_req"}, bus_if.bus_req, 32'd0);
    checkOutput({tag, ".idle_ready"}, req_ready, 32'd1);
    step;
    checkOutput({tag, ".done_once"}, done, 32'd0);
  endtask

  task applyMisaligned(input string tag, input logic b, input logic h, input logic [31:0] a);
    present(1'b0, b, h, 1'b0, a, 32'h0);
    step;
    req_valid = 1'b0;
    checkOutput({tag, ".misalign_err"}, misalign_err, 32'd1);
    checkOutput({tag, ".done"}, done, 32'd0);
    checkOutput({tag, ".bus_req"}, bus_if.bus_req, 32'd0);
    checkOutput({tag, ".ready"}, req_ready, 32'd1);
    step;
    checkOutput({tag, ".misalign_pulse"}, misalign_err, 32'd0);
    checkOutput({tag, ".bus_req_after"}, bus_if.bus_req, 32'd0);
  endtask

  initial begin
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'h0;

    #2;
    checkOutput("rst.ready", req_ready, 32'd1);
    checkOutput("rst.done", done, 32'd0);
    checkOutput("rst.misalign", misalign_err, 32'd0);
    checkOutput("rst.load_data", load_data, 32'd0);
    checkOutput("rst.bus_req", bus_if.bus_req, 32'd0);
    checkOutput("rst.bus_be", bus_if.bus_be, 32'd0);
    checkOutput("rst.bus_addr", bus_if.bus_addr, 32'd0);
    checkOutput("rst.bus_wdata", bus_if.bus_wdata, 32'd0);
    step;
    resetn = 1'b1;
    step;

    applyStimulus("sb", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 2,
                  4'b1000, 32'h0000_1000, 32'hABAB_ABAB, 32'h0);
    applyStimulus("sb_bh", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_5002, 32'h1234_5677, 32'h0, 0,
                  4'b0100, 32'h0000_5000, 32'h7777_7777, 32'h0);
    applyStimulus("sh", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_6002, 32'hFFFF_BEEF, 32'h0, 1,
                  4'b1100, 32'h0000_6000, 32'hBEEF_BEEF, 32'h0);
    applyStimulus("lh", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0,
                  4'b1100, 32'h0000_2000, 32'h0, 32'hFFFF_8001);
    applyStimulus("lhu", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 1,
                  4'b1100, 32'h0000_2000, 32'h0, 32'h0000_8001);
    applyStimulus("lh_lo", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'h0, 32'h8001_9234, 0,
                  4'b0011, 32'h0000_2000, 32'h0, 32'hFFFF_9234);
    applyStimulus("lb", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3001, 32'h0, 32'h0000_F000, 0,
                  4'b0010, 32'h0000_3000, 32'h0, 32'hFFFF_FFF0);
    applyStimulus("lbu", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3002, 32'h0, 32'h00AB_0000, 0,
                  4'b0100, 32'h0000_3000, 32'h0, 32'h0000_00AB);
    applyStimulus("lw", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'h0, 32'h89AB_CDEF, 2,
                  4'b1111, 32'h0000_4000, 32'h0, 32'h89AB_CDEF);

    applyMisaligned("lw_mis", 1'b0, 1'b0, 32'h0000_4002);
    applyMisaligned("lh_mis", 1'b0, 1'b1, 32'h0000_2001);

    // Reset while a load is waiting for read data
    present(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_8000, 32'h0);
    step;
    req_valid      = 1'b0;
    bus_if.bus_gnt = 1'b1;
    step;
    bus_if.bus_gnt = 1'b0;
    checkOutput("rstw.in_wait", req_ready, 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rstw.async_ready", req_ready, 32'd1);
    checkOutput("rstw.async_bus_req", bus_if.bus_req, 32'd0);
    step;
    resetn            = 1'b1;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h1234_5678;
    step;
    bus_if.bus_rvalid = 1'b0;
    checkOutput("rstw.no_done", done, 32'd0);
    checkOutput("rstw.ready", req_ready, 32'd1);
    checkOutput("rstw.bus_req", bus_if.bus_req, 32'd0);
    checkOutput("rstw.load_data", load_data, 32'd0);

    // Back-to-back store then load with a zero-wait bus
    present(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h1122_3344);
    step;
    checkOutput("b2b.sw_addr", bus_if.bus_addr, 32'h0000_0010);
    checkOutput("b2b.sw_wdata", bus_if.bus_wdata, 32'h1122_3344);
    checkOutput("b2b.sw_be", bus_if.bus_be, 32'h0000_000F);
    present(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 32'h0);
    bus_if.bus_gnt = 1'b1;
    step;
    checkOutput("b2b.sw_done", done, 32'd1);
    checkOutput("b2b.ready_in_done", req_ready, 32'd1);
    step;
    req_valid = 1'b0;
    checkOutput("b2b.lw_accepted", bus_if.bus_req, 32'd1);
    checkOutput("b2b.lw_addr", bus_if.bus_addr, 32'h0000_0014);
    checkOutput("b2b.lw_we", bus_if.bus_we, 32'd0);
    checkOutput("b2b.done_low", done, 32'd0);
    step;
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hCAFE_BABE;
    step;
    bus_if.bus_rvalid = 1'b0;
    checkOutput("b2b.lw_done", done, 32'd1);
    checkOutput("b2b.lw_data", load_data, 32'hCAFE_BABE);
    step;
    checkOutput("b2b.lw_done_once", done, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
